mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_bus_pkg.sv | 26 ++
 rtl/mem_lane_mask.sv | 29 ++
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states and the error fill pattern.
package mem_bus_pkg;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  localparam logic [31:0] ERR_PATTERN = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True when the access is misaligned for its size or uses a reserved size code.
  function automatic logic access_fault(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  access_fault = 1'b0;
      SIZE_H:  access_fault = addr_lo[0];
      SIZE_W:  access_fault = (addr_lo != 2'b00);
      default: access_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_mask.sv
// Store byte-enable and lane-data generation: right-justified wdata is replicated across lanes.
module mem_lane_mask
  import mem_bus_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_data
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    be        = 4'b1111;
    lane_data = wdata;
    case (size)
      SIZE_B: begin
        be        = 4'b0001 << addr_lo;
        lane_data = {4{wdata[7:0]}};
      end
      SIZE_H: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        lane_data = {2{wdata[15:0]}};
      end
      default: ;  // word and reserved sizes write all four lanes
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed wait states and byte-lane stores.
// Optional error reporting (err port, range/alignment checks) is enabled by defining MEM_RESP_ERR_EN.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        valid,
  input  logic        write,
  input  logic [2:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready
`ifdef MEM_RESP_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic        write_q, write_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic [29:0] word_off;
  logic [AW-1:0] word_idx;
  logic [3:0]  be;
  logic [31:0] lane_data;
  logic [31:0] load_word;
  logic        resp_err;
  logic        commit;

  assign word_off = 30'((addr_q - BASE_ADDR) >> 2);
  assign word_idx = word_off[AW-1:0];

  mem_lane_mask u_lane_mask (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .be        (be),
    .lane_data (lane_data)
  );

`ifdef MEM_RESP_ERR_EN
  assign resp_err  = (word_off[29:AW] != '0) || access_fault(size_q, addr_q[1:0]);
  assign load_word = resp_err ? ERR_PATTERN : mem[word_idx];
  assign err       = ready && resp_err;
`else
  logic unused_off;
  assign unused_off = ^word_off[29:AW];
  assign resp_err   = 1'b0;
  assign load_word  = mem[word_idx];
`endif

  assign ready  = (state_q == ST_RESP);
  assign rdata  = (ready && !write_q) ? load_word : rdata_q;
  assign commit = ready && write_q && !resp_err;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (valid && !ready) begin
          addr_d  = addr;
          wdata_d = wdata;
          size_d  = size;
          write_d = write;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = 4'(WAIT_CYCLES) - 4'd1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = ST_RESP;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (!write_q) rdata_d = load_word;  // held until the next load response
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      size_q     <= 3'd0;
      write_q    <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
    end
  end

  // NOTE: storage has no reset; contents survive rstb, and a reset abandons the store because
  // the FSM leaves RESP asynchronously.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (0 and 3 wait states) driven by directed loads/stores
// with a scoreboard of expected responses.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rstb;
  logic        valid   [2];
  logic        write   [2];
  logic [2:0]  size    [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic [31:0] rdata_w [2];
  logic        ready_w [2];
`ifdef MEM_RESP_ERR_EN
  logic        err_w   [2];
`endif

  int tests = 0;
  int fails = 0;
  int wait_of [2] = '{0, 3};
  logic [31:0] last_load [2] = '{32'd0, 32'd0};

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk   (clk),
    .rstb  (rstb),
    .valid (valid[0]),
    .write (write[0]),
    .size  (size[0]),
    .addr  (addr[0]),
    .wdata (wdata[0]),
    .rdata (rdata_w[0]),
    .ready (ready_w[0])
`ifdef MEM_RESP_ERR_EN
    ,
    .err   (err_w[0])
`endif
  );

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_dut3 (
    .clk   (clk),
    .rstb  (rstb),
    .valid (valid[1]),
    .write (write[1]),
    .size  (size[1]),
    .addr  (addr[1]),
    .wdata (wdata[1]),
    .rdata (rdata_w[1]),
    .ready (ready_w[1])
`ifdef MEM_RESP_ERR_EN
    ,
    .err   (err_w[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on responder d, then scramble the inputs and wait for the response.
  task automatic txn(input int d, input string tag, input logic wr, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_load, input logic exp_err);
    exp_t e;
    exp_t got;
    int   lat;
    bit   seen;
    e.tag   = tag;
    e.err   = exp_err;
    e.rdata = wr ? last_load[d] : exp_load;
    if (!wr) last_load[d] = exp_load;
    exp_q.push_back(e);

    @(negedge clk);
    valid[d] = 1'b1; write[d] = wr; size[d] = sz; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    #1;
    valid[d] = 1'b0; write[d] = ~wr; size[d] = 3'($urandom);
    addr[d]  = $urandom; wdata[d] = $urandom;

    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ready_w[d] === 1'b1) seen = 1'b1;
      else                     lat++;
    end
    check({tag, " ready seen"}, 32'(seen), 32'd1);
    if (seen) begin
      got = exp_q.pop_front();
      check({got.tag, " latency"}, 32'(lat), 32'(wait_of[d]));
      check({got.tag, " rdata"}, rdata_w[d], got.rdata);
`ifdef MEM_RESP_ERR_EN
      check({got.tag, " err"}, 32'(err_w[d]), 32'(got.err));
`endif
      @(negedge clk);
      check({got.tag, " ready width"}, 32'(ready_w[d]), 32'd0);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; write[d] = 1'b0; size[d] = 3'd0; addr[d] = 32'd0; wdata[d] = 32'd0;
    end
    rstb = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset ready%0d", d), 32'(ready_w[d]), 32'd0);
      check($sformatf("reset rdata%0d", d), rdata_w[d], 32'd0);
`ifdef MEM_RESP_ERR_EN
      check($sformatf("reset err%0d", d), 32'(err_w[d]), 32'd0);
`endif
    end
    repeat (2) @(negedge clk);
    rstb = 1'b1;

    // Zero-wait responder: word, byte and half stores read back as full words.
    txn(0, "sw 0x0",      1'b1, 3'd2, 32'h00, 32'h0BADF00D, 32'h0, 1'b0);
    txn(0, "sw 0x10",     1'b1, 3'd2, 32'h10, 32'h12345678, 32'h0, 1'b0);
    txn(0, "lw 0x10",     1'b0, 3'd2, 32'h10, 32'h0,        32'h12345678, 1'b0);
    txn(0, "sb 0x13",     1'b1, 3'd0, 32'h13, 32'h000000AB, 32'h0, 1'b0);
    txn(0, "lw 0x10 b",   1'b0, 3'd2, 32'h10, 32'h0,        32'hAB345678, 1'b0);
    txn(0, "sw 0x20 z",   1'b1, 3'd2, 32'h20, 32'h00000000, 32'h0, 1'b0);
    txn(0, "sh 0x22",     1'b1, 3'd1, 32'h22, 32'h0000BEEF, 32'h0, 1'b0);
    txn(0, "lw 0x20 h",   1'b0, 3'd2, 32'h20, 32'h0,        32'hBEEF0000, 1'b0);
    txn(0, "sb 0x21",     1'b1, 3'd0, 32'h21, 32'hFFFFFF5A, 32'h0, 1'b0);
    txn(0, "lw 0x20 b1",  1'b0, 3'd2, 32'h20, 32'h0,        32'hBEEF5A00, 1'b0);
`ifdef MEM_RESP_ERR_EN
    txn(0, "lw 0x11 mis", 1'b0, 3'd2, 32'h11,  32'h0,        32'hDEADBEEF, 1'b1);
    txn(0, "sw oob",      1'b1, 3'd2, 32'h100, 32'h55555555, 32'h0, 1'b1);
    txn(0, "lw 0x0 keep", 1'b0, 3'd2, 32'h00,  32'h0,        32'h0BADF00D, 1'b0);
    txn(0, "sh 0x21 mis", 1'b1, 3'd1, 32'h21,  32'h00007777, 32'h0, 1'b1);
    txn(0, "lw rsv size", 1'b0, 3'd5, 32'h20,  32'h0,        32'hDEADBEEF, 1'b1);
    txn(0, "lw 0x20 keep",1'b0, 3'd2, 32'h20,  32'h0,        32'hBEEF5A00, 1'b0);
`else
    txn(0, "lw wrap",     1'b0, 3'd2, 32'h110, 32'h0,        32'hAB345678, 1'b0);
    txn(0, "sw rsv size", 1'b1, 3'd3, 32'h40,  32'h11223344, 32'h0, 1'b0);
    txn(0, "lw 0x40",     1'b0, 3'd2, 32'h40,  32'h0,        32'h11223344, 1'b0);
    txn(0, "sh 0x21 mis", 1'b1, 3'd1, 32'h21,  32'h00007777, 32'h0, 1'b0);
    txn(0, "lw 0x20 mis", 1'b0, 3'd2, 32'h20,  32'h0,        32'hBEEF7777, 1'b0);
`endif

    // Three-wait responder.
    txn(1, "w3 sw 0x30",  1'b1, 3'd2, 32'h30, 32'hCAFE0001, 32'h0, 1'b0);
    txn(1, "w3 lw 0x30",  1'b0, 3'd2, 32'h30, 32'h0,        32'hCAFE0001, 1'b0);

    // Reset during the wait states of a store: no response, no commit.
    @(negedge clk);
    valid[1] = 1'b1; write[1] = 1'b1; size[1] = 3'd2; addr[1] = 32'h30; wdata[1] = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    valid[1] = 1'b0;
    @(negedge clk);
    rstb = 1'b0;
    #1;
    check("rst mid ready", 32'(ready_w[1]), 32'd0);
    check("rst mid rdata", rdata_w[1], 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rstb = 1'b1;
      check($sformatf("rst ready c%0d", i), 32'(ready_w[1]), 32'd0);
    end
    last_load[0] = 32'd0;
    last_load[1] = 32'd0;

    txn(1, "w3 lw after rst", 1'b0, 3'd2, 32'h30, 32'h0, 32'hCAFE0001, 1'b0);
    txn(0, "lw 0x10 after rst", 1'b0, 3'd2, 32'h10, 32'h0, 32'hAB345678, 1'b0);

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
